// File: rtl/tdm_mux_pkg.sv
// Shared types and helpers for the TDM multiplexer and its round-robin arbiter.
package tdm_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_t;

  // Index width for n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_mux_if.sv
// Channel-side and output-side signals of the TDM multiplexer bundled as one interface.
interface tdm_mux_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  import tdm_mux_pkg::*;

  localparam int SELW = sel_width(N_CH);

  mode_t                   mode;
  logic [SELW-1:0]         sel;
  logic [N_CH*WIDTH-1:0]   in_data;
  logic [N_CH-1:0]         in_valid;
  logic [N_CH-1:0]         in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SELW-1:0]         out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/tdm_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requesting index at or above ptr, wrapping at N-1.
module rr_arbiter
  import tdm_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            grant_valid,
  output logic [SELW-1:0] grant_idx
);

  localparam logic [SELW:0] N_W = (SELW + 1)'(N);

  logic [SELW-1:0] cand [N];
  logic [N-1:0]    rot;

  // rot[k] is the request of the channel k steps past ptr.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [SELW:0] sum;
      logic [SELW:0] wrapped;
      assign sum         = {1'b0, ptr} + (SELW + 1)'(gi);
      assign wrapped     = (sum >= N_W) ? (sum - N_W) : sum;
      assign cand[gi]    = wrapped[SELW-1:0];
      assign rot[gi]     = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[i];
      end
    end
  end

endmodule

// File: rtl/tdm_mux.sv
// N-channel time-division multiplexer with manual or round-robin channel selection
// feeding a single registered valid/ready output stage.
module tdm_mux
  import tdm_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  tdm_mux_if.slave  bus
);

  localparam int              SELW    = sel_width(N_CH);
  localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(N_CH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N_CH - 1);

  logic [WIDTH-1:0] chan_data [N_CH];
  logic [N_CH-1:0]  ready_vec;

  logic [SELW-1:0]  ptr_reg, ptr_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [SELW-1:0]  out_ch_reg, out_ch_next;
  logic             out_valid_reg, out_valid_next;

  logic             load_en;
  logic             rr_valid, man_valid;
  logic [SELW-1:0]  rr_idx;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;

  assign load_en = !out_valid_reg || bus.out_ready;

  rr_arbiter #(
    .N    (N_CH),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req         (bus.in_valid),
    .ptr         (ptr_reg),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  // An out-of-range sel simply produces no grant.
  assign man_valid = ({1'b0, bus.sel} < NCH_W) && bus.in_valid[bus.sel];

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (bus.mode == MODE_RR) begin
      grant_valid = rr_valid;
      grant_idx   = rr_idx;
    end else begin
      grant_valid = man_valid;
      grant_idx   = bus.sel;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      assign chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
      assign ready_vec[gi] = !rst && load_en && grant_valid && (grant_idx == SELW'(gi));
    end
  endgenerate

  assign bus.in_ready = ready_vec;

  always_comb begin
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    out_valid_next = out_valid_reg;
    ptr_next       = ptr_reg;
    if (load_en) begin
      out_valid_next = grant_valid;
      if (grant_valid) begin
        out_data_next = chan_data[grant_idx];
        out_ch_next   = grant_idx;
        // The pointer only moves past a channel that actually transferred.
        if (bus.mode == MODE_RR) begin
          ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else begin
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
      out_valid_reg <= out_valid_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.out_valid = out_valid_reg;

endmodule
